// File: rtl/regfile_writeback.sv
// Write-side controller for the register file: in-order result queue with
// pending-write vector. Optional operand lookup when REGFILE_WB_BYPASS_EN is defined.
module regfile_writeback #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int NREG  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef REGFILE_WB_BYPASS_EN
  input  logic [4:0]               i_byp_addr0,
  input  logic [4:0]               i_byp_addr1,
  output logic                     o_byp_hit0,
  output logic                     o_byp_hit1,
  output logic [XLEN-1:0]          o_byp_data0,
  output logic [XLEN-1:0]          o_byp_data1,
`endif
  input  logic                     i_ld_valid,
  output logic                     o_ld_ready,
  input  logic [4:0]               i_ld_rd,
  input  logic [XLEN-1:0]          i_ld_data,
  input  logic                     i_alu_valid,
  output logic                     o_alu_ready,
  input  logic [4:0]               i_alu_rd,
  input  logic [XLEN-1:0]          i_alu_data,
  input  logic                     i_wb_hold,
  output logic                     o_rf_we,
  output logic [4:0]               o_rf_waddr,
  output logic [XLEN-1:0]          o_rf_wdata,
  output logic [NREG-1:0]          o_busy,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [4:0]       r_rd   [DEPTH];
  logic [XLEN-1:0]  r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic [4:0]       r_last_addr;
  logic [XLEN-1:0]  r_last_data;

  logic             w_not_full;
  logic             w_acc_ld;
  logic             w_acc_alu;
  logic             w_push;
  logic             w_pop;
  logic [4:0]       w_push_rd;
  logic [XLEN-1:0]  w_push_data;
  logic [DEPTH-1:0] w_push_mask;
  logic [DEPTH-1:0] w_pop_mask;
  logic [NREG-1:0]  w_busy;

  // Full test looks only at the registered count, so a same-cycle drain never frees a slot.
  assign w_not_full  = (r_count < FULL);
  assign o_ld_ready  = w_not_full;
  assign o_alu_ready = w_not_full & ~i_ld_valid;
  assign w_acc_ld    = i_ld_valid & w_not_full;
  assign w_acc_alu   = i_alu_valid & o_alu_ready;
  assign w_push_rd   = w_acc_ld ? i_ld_rd : i_alu_rd;
  assign w_push_data = w_acc_ld ? i_ld_data : i_alu_data;
  assign w_push      = (w_acc_ld | w_acc_alu) & (w_push_rd != 5'd0);
  assign w_pop       = (r_count != {(AW+1){1'b0}}) & ~i_wb_hold;

  assign w_push_mask = {DEPTH{w_push}} & ({{(DEPTH-1){1'b0}}, 1'b1} << r_wptr);
  assign w_pop_mask  = {DEPTH{w_pop}}  & ({{(DEPTH-1){1'b0}}, 1'b1} << r_rptr);

  // Write port shows the head while draining, otherwise the last written pair.
  assign o_rf_we    = w_pop;
  assign o_rf_waddr = w_pop ? r_rd[r_rptr]   : r_last_addr;
  assign o_rf_wdata = w_pop ? r_data[r_rptr] : r_last_data;
  assign o_count    = r_count;

  // Queue storage, pointers, occupancy and last-written registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i]   <= 5'd0;
        r_data[i] <= {XLEN{1'b0}};
      end
      r_vld       <= {DEPTH{1'b0}};
      r_wptr      <= {AW{1'b0}};
      r_rptr      <= {AW{1'b0}};
      r_count     <= {(AW+1){1'b0}};
      r_last_addr <= 5'd0;
      r_last_data <= {XLEN{1'b0}};
    end else begin
      if (w_push) begin
        r_rd[r_wptr]   <= w_push_rd;
        r_data[r_wptr] <= w_push_data;
        r_wptr         <= r_wptr + {{(AW-1){1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_last_addr <= r_rd[r_rptr];
        r_last_data <= r_data[r_rptr];
        r_rptr      <= r_rptr + {{(AW-1){1'b0}}, 1'b1};
      end
      r_vld   <= (r_vld & ~w_pop_mask) | w_push_mask;
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  // Pending-write vector: one bit per destination of every occupied entry.
  always_comb begin
    w_busy = {NREG{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      w_busy = w_busy | ({{(NREG-1){1'b0}}, r_vld[i]} << r_rd[i]);
    end
    w_busy[0] = 1'b0;
  end

  assign o_busy = w_busy;

`ifdef REGFILE_WB_BYPASS_EN
  logic [AW-1:0] w_idx;
  logic          w_m0;
  logic          w_m1;

  // Walk oldest to youngest so the youngest matching entry supplies the data.
  always_comb begin
    o_byp_hit0  = 1'b0;
    o_byp_hit1  = 1'b0;
    o_byp_data0 = {XLEN{1'b0}};
    o_byp_data1 = {XLEN{1'b0}};
    w_idx       = r_rptr;
    w_m0        = 1'b0;
    w_m1        = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx       = r_rptr + AW'(k);
      w_m0        = r_vld[w_idx] & (r_rd[w_idx] == i_byp_addr0) & (i_byp_addr0 != 5'd0);
      w_m1        = r_vld[w_idx] & (r_rd[w_idx] == i_byp_addr1) & (i_byp_addr1 != 5'd0);
      o_byp_hit0  = o_byp_hit0 | w_m0;
      o_byp_hit1  = o_byp_hit1 | w_m1;
      o_byp_data0 = w_m0 ? r_data[w_idx] : o_byp_data0;
      o_byp_data1 = w_m1 ? r_data[w_idx] : o_byp_data1;
    end
  end
`endif

endmodule
